// File: rtl/rr_burst_arbiter_pkg.sv
// Shared types and the round-robin search for the burst arbiter.
//   state_t : arbiter FSM states (IDLE, GRANT, GAP)
//   pick_t  : result of a round-robin search (found flag + index)
//   rr_pick : first asserted request at or above ptr, wrapping at n
package rr_burst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int unsigned MAX_NREQ = 8;
  localparam int unsigned MAX_IW   = 3;

  typedef struct packed {
    logic              found;
    logic [MAX_IW-1:0] idx;
  } pick_t;

  // Walk n positions starting at ptr; ptr < n and k < n, so one subtract wraps.
  function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] req,
                                    input logic [MAX_IW-1:0]   ptr,
                                    input int unsigned         n);
    pick_t       res;
    int unsigned j;
    res = '0;
    for (int unsigned k = 0; k < MAX_NREQ; k++) begin
      j = 32'(ptr) + k;
      if (j >= n) j = j - n;
      if ((k < n) && !res.found && req[j[MAX_IW-1:0]]) begin
        res.found = 1'b1;
        res.idx   = j[MAX_IW-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_burst_arbiter_if.sv
// Requester/channel bundle for rr_burst_arbiter.
//   req, data          : per-requester request level and serial bit
//   gnt, owner         : registered one-hot grant and owner index
//   ch_valid, ch_data  : shared channel beat
//   tap, burst_done    : ones-count tap and end-of-burst pulse
// master = requester side, slave = arbiter side.
interface rr_burst_arbiter_if #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IW   = $clog2(NREQ)
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] data;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   owner;
  logic            ch_valid;
  logic            ch_data;
  logic            tap;
  logic            burst_done;

  modport master (output req, data,
                  input  gnt, owner, ch_valid, ch_data, tap, burst_done);
  modport slave  (input  req, data,
                  output gnt, owner, ch_valid, ch_data, tap, burst_done);
endinterface

// File: rtl/rr_burst_arbiter_pick.sv
// Combinational round-robin selector: rotate from i_ptr and priority-encode.
//   i_req    : request vector
//   i_ptr    : starting index for the search
//   o_found  : any request asserted
//   o_idx    : selected index
//   o_onehot : selected index as one-hot, zero when nothing found
module rr_pick_onehot
  import rr_burst_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic            o_found,
  output logic [IW-1:0]   o_idx,
  output logic [NREQ-1:0] o_onehot
);

  pick_t w_pick;

  always_comb w_pick = rr_pick(MAX_NREQ'(i_req), MAX_IW'(i_ptr), NREQ);

  assign o_found  = w_pick.found;
  assign o_idx    = IW'(w_pick.idx);
  assign o_onehot = w_pick.found ? (NREQ'(1) << o_idx) : '0;

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter for a shared serial bit channel.
//   clk   : clock
//   reset : asynchronous, active-high
//   bus   : requester/channel bundle (slave side)
// A grant lasts up to BURST beats or until the owner drops req, followed by
// a single idle GAP cycle during which burst_done pulses and the next owner
// is chosen starting just above the previous owner.
module rr_burst_arbiter
  import rr_burst_pkg::*;
#(
  parameter  int unsigned NREQ  = 4,
  parameter  int unsigned BURST = 8,
  localparam int unsigned BW    = $clog2(BURST),
  localparam int unsigned IW    = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  rr_burst_arbiter_if.slave    bus
);

  state_t          r_state,      w_nxt_state;
  logic [NREQ-1:0] r_gnt,        w_nxt_gnt;
  logic [IW-1:0]   r_owner,      w_nxt_owner;
  logic [IW-1:0]   r_ptr,        w_nxt_ptr;
  logic [BW-1:0]   r_beat,       w_nxt_beat;
  logic [1:0]      r_ones,       w_nxt_ones;
  logic            r_burst_done, w_nxt_burst_done;

  logic            w_found;
  logic [IW-1:0]   w_sel;
  logic [NREQ-1:0] w_sel_onehot;
  logic            w_owner_req;
  logic            w_owner_data;
  logic            w_last_beat;
  logic            w_ch_valid;

  rr_pick_onehot #(.NREQ(NREQ)) u_pick (
    .i_req    (bus.req),
    .i_ptr    (r_ptr),
    .o_found  (w_found),
    .o_idx    (w_sel),
    .o_onehot (w_sel_onehot)
  );

  assign w_owner_req  = bus.req[r_owner];
  assign w_owner_data = bus.data[r_owner];
  assign w_last_beat  = (r_beat == BW'(BURST - 1));
  assign w_ch_valid   = |r_gnt;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_gnt        <= '0;
      r_owner      <= '0;
      r_ptr        <= '0;
      r_beat       <= '0;
      r_ones       <= '0;
      r_burst_done <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_gnt        <= w_nxt_gnt;
      r_owner      <= w_nxt_owner;
      r_ptr        <= w_nxt_ptr;
      r_beat       <= w_nxt_beat;
      r_ones       <= w_nxt_ones;
      r_burst_done <= w_nxt_burst_done;
    end
  end

  // Next-state: IDLE and GAP arbitrate identically; GRANT counts beats and ones
  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_gnt        = r_gnt;
    w_nxt_owner      = r_owner;
    w_nxt_ptr        = r_ptr;
    w_nxt_beat       = r_beat;
    w_nxt_ones       = r_ones;
    w_nxt_burst_done = 1'b0;

    case (r_state)
      IDLE, GAP: begin
        w_nxt_gnt = '0;
        if (w_found) begin
          w_nxt_state = GRANT;
          w_nxt_gnt   = w_sel_onehot;
          w_nxt_owner = w_sel;
          w_nxt_beat  = '0;
          w_nxt_ones  = '0;
        end else begin
          w_nxt_state = IDLE;
        end
      end
      GRANT: begin
        // The current beat is forwarded and counted even when it is the last
        w_nxt_beat = r_beat + BW'(1);
        if (w_owner_data) w_nxt_ones = r_ones + 2'd1;
        if (w_last_beat || !w_owner_req) begin
          w_nxt_state      = GAP;
          w_nxt_gnt        = '0;
          w_nxt_ptr        = (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + IW'(1);
          w_nxt_burst_done = 1'b1;
        end
      end
      default: begin
        w_nxt_state = IDLE;
        w_nxt_gnt   = '0;
      end
    endcase
  end

  assign bus.gnt        = r_gnt;
  assign bus.owner      = r_owner;
  assign bus.ch_valid   = w_ch_valid;
  assign bus.ch_data    = w_ch_valid & w_owner_data;
  assign bus.tap        = w_ch_valid && (r_ones == 2'd1);
  assign bus.burst_done = r_burst_done;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Self-checking bench for rr_burst_arbiter: directed scenarios plus random
// request/data traffic, compared each cycle against a transaction-level model.
module tb_rr_burst_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned BURST = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  rr_burst_arbiter_if #(.NREQ(NREQ)) bus ();

  rr_burst_arbiter #(.NREQ(NREQ), .BURST(BURST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Model: current owner (-1 = none), beats done, total ones seen, next start
  int m_owner;
  int m_beat;
  int m_ones;
  int m_ptr;
  bit m_done;

  int              owners[$];
  logic            pv;
  int              cnt2;
  int              dcount;
  logic [NREQ-1:0] r;
  int              pat[8];
  int              etap[8];
  int              exp_rot[6];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_beat  = 0;
    m_ones  = 0;
    m_ptr   = 0;
    m_done  = 1'b0;
  endtask

  task automatic model_step();
    if (m_owner >= 0) begin
      bit last;
      last = (m_beat == int'(BURST) - 1) || (bus.req[m_owner] == 1'b0);
      if (bus.data[m_owner]) m_ones++;
      m_beat++;
      if (last) begin
        m_ptr   = (m_owner + 1) % int'(NREQ);
        m_owner = -1;
        m_done  = 1'b1;
      end
    end else begin
      m_done = 1'b0;
      for (int k = 0; k < int'(NREQ); k++) begin
        int c;
        c = (m_ptr + k) % int'(NREQ);
        if (m_owner < 0 && bus.req[c]) begin
          m_owner = c;
          m_beat  = 0;
          m_ones  = 0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [NREQ-1:0] eg;
    logic            ed;
    eg = '0;
    ed = 1'b0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ed          = bus.data[m_owner];
    end
    check("gnt",        32'(bus.gnt),        32'(eg));
    check("ch_valid",   32'(bus.ch_valid),   32'(m_owner >= 0));
    check("ch_data",    32'(bus.ch_data),    32'(ed));
    check("tap",        32'(bus.tap),        32'((m_owner >= 0) && (m_ones % 4 == 1)));
    check("burst_done", 32'(bus.burst_done), 32'(m_done));
    if (m_owner >= 0) check("owner", 32'(bus.owner), 32'(m_owner));
  endtask

  // One clock: advance model at the edge, then drive next inputs and check
  task automatic step(input logic [NREQ-1:0] nreq, input logic [NREQ-1:0] ndata);
    @(posedge clk);
    model_step();
    #1;
    bus.req  = nreq;
    bus.data = ndata;
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    bus.req  = '0;
    bus.data = '0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    pat     = '{1, 1, 1, 1, 1, 0, 0, 0};
    etap    = '{0, 1, 0, 0, 0, 1, 1, 1};
    exp_rot = '{0, 1, 3, 0, 1, 3};

    reset    = 1'b1;
    bus.req  = '0;
    bus.data = '0;
    model_reset();
    #12;
    check("rst_gnt",   32'(bus.gnt),        32'd0);
    check("rst_valid", 32'(bus.ch_valid),   32'd0);
    check("rst_tap",   32'(bus.tap),        32'd0);
    check("rst_done",  32'(bus.burst_done), 32'd0);
    check("rst_owner", 32'(bus.owner),      32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Sole requester, data all ones: two bursts separated by one GAP
    repeat (22) step(4'b0001, 4'b1111);

    // Rotation over requesters 0,1,3
    do_reset();
    pv   = 1'b0;
    cnt2 = 0;
    for (int i = 0; i < 56; i++) begin
      step(4'b1011, 4'($urandom));
      if (bus.ch_valid && !pv) owners.push_back(int'(bus.owner));
      if (bus.gnt[2]) cnt2++;
      pv = bus.ch_valid;
    end
    check("rot_bursts", 32'(owners.size() >= 6), 32'd1);
    for (int i = 0; i < 6 && i < owners.size(); i++) check("rot_owner", 32'(owners[i]), 32'(exp_rot[i]));
    check("rot_no_idx2", 32'(cnt2), 32'd0);

    // Early release by owner 1 on beat 3; req[2] rising mid-burst is ignored
    do_reset();
    repeat (4) step(4'b0010, 4'($urandom));
    step(4'b1101, 4'($urandom));
    check("er_beat3_valid", 32'(bus.ch_valid), 32'd1);
    step(4'b1101, 4'($urandom));
    check("er_gap_gnt",  32'(bus.gnt),        32'd0);
    check("er_gap_done", 32'(bus.burst_done), 32'd1);
    step(4'b1101, 4'($urandom));
    check("er_next_owner", 32'(bus.owner), 32'd2);

    // Ones counter wrap
    do_reset();
    step(4'b0001, 4'b0000);
    for (int i = 0; i < 8; i++) begin
      step(4'b0001, 4'(pat[i]));
      check("ones_tap", 32'(bus.tap), 32'(etap[i]));
    end
    repeat (3) step(4'b0001, 4'($urandom));

    // Asynchronous reset during beat 4 while tap is high
    do_reset();
    step(4'b0001, 4'b0000);
    step(4'b0001, 4'b0001);
    repeat (4) step(4'b0001, 4'b0000);
    check("ar_tap_pre", 32'(bus.tap), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("ar_gnt",   32'(bus.gnt),      32'd0);
    check("ar_valid", 32'(bus.ch_valid), 32'd0);
    check("ar_tap",   32'(bus.tap),      32'd0);
    bus.req  = 4'b0100;
    bus.data = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(4'b0100, 4'b0000);
    check("ar_owner", 32'(bus.owner), 32'd2);

    // Requests vanish: one burst_done, then quiet IDLE
    dcount = 0;
    repeat (20) begin
      step(4'b0000, 4'($urandom));
      if (bus.burst_done) dcount++;
    end
    check("idle_done_cnt", 32'(dcount), 32'd1);
    check("idle_gnt",      32'(bus.gnt), 32'd0);

    // Random traffic
    do_reset();
    r = 4'($urandom);
    repeat (800) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      step(r, 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_burst_arbiter.md
Name: rr_burst_arbiter

Overview:
- Round-robin arbiter that shares one serial bit channel among NREQ requesters.
- Each grant is a bounded burst. During the burst the block forwards the owner's data bit and counts its ones modulo 4.
- Sits in front of the FSM-style serial detectors. It schedules which source drives the shared din line, and when.

Parameters:
- NREQ, 4, number of requesters (2..8)
- BURST, 8, maximum beats per grant (2..255)
- BW, $clog2(BURST), beat counter width
- IW, $clog2(NREQ), owner index width

Ports:
- clk  in  1  single clock; all state changes on posedge clk
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- req  in  NREQ  per-requester request; level, held while data is pending
- data  in  NREQ  per-requester serial bit; sampled only for the current owner
- gnt  out  NREQ  one-hot grant, registered
- owner  out  IW  index of current owner; valid while ch_valid=1
- ch_valid  out  1  shared channel beat valid; equals |gnt
- ch_data  out  1  data[owner] when ch_valid, else 0
- tap  out  1  high while the ones count of the current burst is 1 (mod 4) and ch_valid=1
- burst_done  out  1  one-cycle pulse in the cycle after a burst ends

Behaviour:
- Reset values (asynchronous assertion, synchronous release): state=IDLE, gnt=0, owner=0, ptr=0, beat=0, ones=0, burst_done=0. Outputs drop within the reset assertion; no clock is needed.
- State encoding: IDLE, GRANT, GAP; 2-bit encoding.
- IDLE:
  - If |req=0, stay in IDLE.
  - Else select the first asserted req starting at index ptr, searching upward with wrap.
  - Next cycle: state=GRANT, gnt=onehot(sel), owner=sel, beat=0, ones=0.
  - Latency is 1 cycle from req to gnt.
- GRANT:
  - Each cycle: ch_valid=1 and ch_data=data[owner].
  - If data[owner]=1, ones <= ones+1 (mod 4, 2-bit wrap).
  - beat increments every cycle.
- GRANT exit: taken when beat==BURST-1, or when req[owner]=0 (sampled that cycle, whichever comes first).
  - Next cycle: state=GAP, gnt=0, ptr=(owner+1) mod NREQ, burst_done=1.
  - If req[owner] drops, the beat in that cycle is still a valid beat; it is forwarded and counted.
- GAP:
  - gnt=0 and ch_valid=0 for exactly one cycle. This is the idle bit between bursts.
  - burst_done=1 in this cycle only.
  - Arbitration uses the same rule as IDLE, with the updated ptr.
  - If any req is asserted, go to GRANT next cycle; else go to IDLE.
- tap: combinational, tap = ch_valid && (ones==2'd1).
  - ones is the count of data ones on beats before the current beat; the current beat's bit is not included.
  - ones wraps 3 -> 0, so tap repeats every 4 ones.
- Fairness:
  - An owner cannot be regranted while another request is pending.
  - A sole requester is regranted after the 1-cycle GAP.
- A new req appearing mid-burst has no effect until the GAP arbitration.
- Requester indices that are out of range cannot occur (NREQ is a parameter); ptr wraps NREQ-1 -> 0.
- Reset mid-burst: gnt, ch_valid and tap drop immediately. After release, the block arbitrates from ptr=0.

Decomposition:
- Package rr_burst_pkg: state_t enum {IDLE, GRANT, GAP}, plus a function rr_pick(req, ptr) that returns the index and a found flag.
- Sub-module rr_pick_onehot: combinational rotate-and-priority-encode, parameterised by NREQ.
- Ones counter and beat counter stay inline.

Test Plan:
- Reset and single requester:
  - Stimulus: assert reset, release; req=4'b0001 held; data=1 every cycle; BURST=8.
  - Required response: gnt=0001 one cycle after req; 8 beats; tap high on beat 1 and beat 5 (beats numbered 0..7); GAP with burst_done=1; regrant next cycle.
- Round-robin rotation:
  - Stimulus: req=4'b1011 held.
  - Required response: owners 0,1,3,0,... in order, each burst 8 beats, 1-cycle GAP between bursts, index 2 never granted.
- Early release:
  - Stimulus: owner 1 drops req[1] on beat 3.
  - Required response: beat 3 valid; gnt=0 on the next cycle; burst_done pulses; ptr=2.
- Ones wrap:
  - Stimulus: data pattern 1,1,1,1,1,0,0,0 on one burst.
  - Required response: ones sequence 0,1,2,3,0,1,1,1; tap high on beats 1, 5, 6 and 7.
- Async reset mid-burst:
  - Stimulus: reset pulses on beat 4, between clock edges.
  - Required response: gnt, ch_valid and tap go to 0 before the next edge; after release with req=4'b0100, owner=2 is granted one cycle later.
- Idle:
  - Stimulus: req=0 for 20 cycles after a burst.
  - Required response: state stays IDLE; all outputs 0; burst_done pulses only once.
